// File: rtl/water_state_ctrl_pkg.sv
// Shared definitions for the water level controller and its display consumer.
// Holds the state encoding, the state width and the probe-to-level mapping.
package water_state_ctrl_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_OFF      = 3'b000,
      ST_EMPTY    = 3'b001,
      ST_LOW      = 3'b010,
      ST_MID      = 3'b011,
      ST_HIGH     = 3'b100,
      ST_FULL     = 3'b101,
      ST_SELFTEST = 3'b110,
      ST_ALARM    = 3'b111
   } state_t;

   // Probe contacts fill from bit0 upward; only these thermometer codes are legal.
   localparam logic [3:0] PROBE_EMPTY = 4'b0000;
   localparam logic [3:0] PROBE_LOW   = 4'b0001;
   localparam logic [3:0] PROBE_MID   = 4'b0011;
   localparam logic [3:0] PROBE_HIGH  = 4'b0111;
   localparam logic [3:0] PROBE_FULL  = 4'b1111;

   typedef struct packed {
      logic   valid;
      state_t level;
   } level_t;

   // Map a debounced probe pattern to its level state; valid=0 for broken patterns.
   function automatic level_t map_level(input logic [3:0] probe);
      level_t r;
      r.valid = 1'b1;
      case (probe)
         PROBE_EMPTY: r.level = ST_EMPTY;
         PROBE_LOW:   r.level = ST_LOW;
         PROBE_MID:   r.level = ST_MID;
         PROBE_HIGH:  r.level = ST_HIGH;
         PROBE_FULL:  r.level = ST_FULL;
         default: begin
            r.valid = 1'b0;
            r.level = ST_ALARM;
         end
      endcase
      return r;
   endfunction

endpackage

// File: rtl/water_state_ctrl_debounce.sv
// Two-flop synchronizer, stability counter and press (rise) pulse for one raw input.
// The rise pulse is only armed once a released input has been seen after reset,
// so a contact held through reset never produces a pulse until pressed again.
module debounce #(
   parameter int DEB_CYCLES = 20
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic level,
   output logic rise
);

   localparam int            CW       = $clog2(DEB_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

   logic          sync1;
   logic          sync2;
   logic [1:0]    primed;
   logic          prev;
   logic          armed;
   logic [CW-1:0] cnt;

   // Synchronize, count consecutive mismatching cycles, and track arming.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1  <= 1'b0;
         sync2  <= 1'b0;
         primed <= 2'b00;
         prev   <= 1'b0;
         armed  <= 1'b0;
         level  <= 1'b0;
         cnt    <= '0;
      end else begin
         sync1  <= raw;
         sync2  <= sync1;
         primed <= {primed[0], 1'b1};
         prev   <= level;
         // sync2 only carries a real sample once both flops have refilled
         if (primed[1] && !sync2 && !level)
            armed <= 1'b1;
         if (sync2 != level) begin
            if (cnt == CNT_LAST) begin
               level <= sync2;
               cnt   <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            cnt <= '0;
         end
      end
   end

   assign rise = armed & level & ~prev;

endmodule

// File: rtl/water_state_ctrl.sv
// Water tank level controller: debounces the probe and buttons, runs a power-up
// self-test, tracks the tank level and raises an alarm on broken probe patterns
// or on a tank that stays full too long.
module water_state_ctrl
   import water_state_ctrl_pkg::*;
#(
   parameter int DEB_CYCLES      = 20,
   parameter int SELFTEST_CYCLES = 1000,
   parameter int FULL_HOLD       = 50
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [3:0]         probe,
   input  logic               btn_pwr,
   input  logic               btn7,
   output logic [STATE_W-1:0] state,
   output logic               fault
);

   localparam int              ST_W    = $clog2(SELFTEST_CYCLES + 1);
   localparam int              FH_W    = $clog2(FULL_HOLD + 1);
   localparam logic [ST_W-1:0] ST_LAST = ST_W'(SELFTEST_CYCLES - 1);
   localparam logic [FH_W-1:0] FH_LAST = FH_W'(FULL_HOLD - 1);

   logic [3:0]      probe_db;
   logic [3:0]      probe_rise_unused;
   logic            pwr_press;
   logic            btn7_press;
   logic            pwr_level_unused;
   logic            btn7_level_unused;
   level_t          lvl;
   state_t          st;
   logic [ST_W-1:0] st_cnt;
   logic [FH_W-1:0] full_cnt;

   for (genvar i = 0; i < 4; i++) begin : g_probe
      debounce #(.DEB_CYCLES(DEB_CYCLES)) u_db (
         .clk   (clk),
         .rst_n (rst_n),
         .raw   (probe[i]),
         .level (probe_db[i]),
         .rise  (probe_rise_unused[i])
      );
   end

   debounce #(.DEB_CYCLES(DEB_CYCLES)) u_db_pwr (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (btn_pwr),
      .level (pwr_level_unused),
      .rise  (pwr_press)
   );

   debounce #(.DEB_CYCLES(DEB_CYCLES)) u_db_btn7 (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (btn7),
      .level (btn7_level_unused),
      .rise  (btn7_press)
   );

   assign lvl   = map_level(probe_db);
   assign state = st;

   // Main controller: power toggling, self-test, level tracking and alarm handling.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st       <= ST_OFF;
         fault    <= 1'b0;
         st_cnt   <= '0;
         full_cnt <= '0;
      end else if (pwr_press) begin
         // power wins over everything else on the same cycle
         st       <= (st == ST_OFF) ? ST_SELFTEST : ST_OFF;
         fault    <= 1'b0;
         st_cnt   <= '0;
         full_cnt <= '0;
      end else begin
         case (st)
            ST_OFF: begin
               st_cnt   <= '0;
               full_cnt <= '0;
            end
            ST_SELFTEST: begin
               if (st_cnt == ST_LAST) begin
                  st_cnt <= '0;
                  if (lvl.valid) begin
                     st <= lvl.level;
                  end else begin
                     st    <= ST_ALARM;
                     fault <= 1'b1;
                  end
               end else begin
                  st_cnt <= st_cnt + 1'b1;
               end
            end
            ST_ALARM: begin
               // fault stays frozen here; acknowledge is refused while the tank is full
               if (btn7_press && lvl.valid && (lvl.level != ST_FULL)) begin
                  st    <= lvl.level;
                  fault <= 1'b0;
               end
            end
            default: begin
               if (!lvl.valid) begin
                  st       <= ST_ALARM;
                  fault    <= 1'b1;
                  full_cnt <= '0;
               end else if ((st == ST_FULL) && (full_cnt == FH_LAST)) begin
                  st       <= ST_ALARM;
                  fault    <= 1'b0;
                  full_cnt <= '0;
               end else begin
                  st <= lvl.level;
                  if ((st == ST_FULL) && (lvl.level == ST_FULL))
                     full_cnt <= full_cnt + 1'b1;
                  else
                     full_cnt <= '0;
               end
            end
         endcase
      end
   end

endmodule
